// File: rtl/fifo_rd_ptr_empty.sv
// Read-side pointer and empty-flag controller for a dual-clock FIFO.
// Lives entirely in the read clock domain. It takes the already
// synchronized Gray write pointer and produces:
//   - the binary RAM read address
//   - the Gray read pointer that is sent to the write domain
//   - registered empty, almost-empty, fill level, read-valid and
//     sticky underflow status
// All flags are computed from next-state values, so a read that drains
// the last entry raises rd_empty on the same edge that moves the pointer.
module fifo_rd_ptr_empty #(
    parameter int ADDR_SIZE = 4,
    parameter int AE_THRESH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd_en,
    input  logic [ADDR_SIZE:0]   wq2_ptr,
    output logic [ADDR_SIZE:0]   rd_ptr,
    output logic [ADDR_SIZE-1:0] rd_addr,
    output logic                 rd_empty,
    output logic                 rd_almost_empty,
    output logic [ADDR_SIZE:0]   rd_level,
    output logic                 rd_valid,
    output logic                 rd_underflow
);

    localparam int            PW       = ADDR_SIZE + 1;
    localparam logic [PW-1:0] AE_LIMIT = PW'(AE_THRESH);

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] wbin;
    logic [PW-1:0] level_next;
    logic          rd_fire;

    // A read is only accepted when the FIFO is not empty; otherwise the
    // pointer stays put and the attempt is recorded as an underflow.
    assign rd_fire    = rd_en & ~rd_empty;
    assign rbin_next  = rbin + {{ADDR_SIZE{1'b0}}, rd_fire};
    assign rgray_next = (rbin_next >> 1) ^ rbin_next;
    assign level_next = wbin - rbin_next;
    assign rd_addr    = rbin[ADDR_SIZE-1:0];

    // Gray-to-binary of the synchronized write pointer: each binary bit is
    // the XOR of all Gray bits from the MSB down to that position.
    always_comb begin
        // NOTE: give every bit a default first so no path leaves wbin
        // unassigned; an incomplete combinational assignment infers a latch.
        wbin = '0;
        for (int i = 0; i < PW; i++) begin
            wbin[i] = ^(wq2_ptr >> i);
        end
    end

    // Pointer and status registers; synchronous reset discards all state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            rbin            <= '0;
            rd_ptr          <= '0;
            rd_empty        <= 1'b1;
            rd_almost_empty <= 1'b1;
            rd_level        <= '0;
            rd_valid        <= 1'b0;
            rd_underflow    <= 1'b0;
        end else begin
            rbin            <= rbin_next;
            rd_ptr          <= rgray_next;
            rd_empty        <= (rgray_next == wq2_ptr);
            rd_almost_empty <= (level_next <= AE_LIMIT);
            rd_level        <= level_next;
            rd_valid        <= rd_fire;
            rd_underflow    <= rd_underflow | (rd_en & rd_empty);
        end
    end

endmodule

// File: tb/tb_fifo_rd_ptr_empty.sv
// Scoreboard bench for fifo_rd_ptr_empty. The stimulus process drives one
// cycle of inputs on the falling edge, advances a count-based reference
// model and queues the outputs expected after the next rising edge. An
// independent monitor pops and compares them 1 ns after each rising edge.
module tb_fifo_rd_ptr_empty;

    localparam int AS    = 4;
    localparam int PW    = AS + 1;
    localparam int DEPTH = 1 << AS;
    localparam int MOD   = 1 << PW;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_en;
    logic [PW-1:0] wq2_ptr;
    logic [PW-1:0] rd_ptr;
    logic [AS-1:0] rd_addr;
    logic          rd_empty;
    logic          rd_almost_empty;
    logic [PW-1:0] rd_level;
    logic          rd_valid;
    logic          rd_underflow;

    fifo_rd_ptr_empty #(.ADDR_SIZE(AS), .AE_THRESH(AE)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rd_en           (rd_en),
        .wq2_ptr         (wq2_ptr),
        .rd_ptr          (rd_ptr),
        .rd_addr         (rd_addr),
        .rd_empty        (rd_empty),
        .rd_almost_empty (rd_almost_empty),
        .rd_level        (rd_level),
        .rd_valid        (rd_valid),
        .rd_underflow    (rd_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ptr;
        int addr;
        int empty;
        int ae;
        int level;
        int valid;
        int uf;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: plain read/write entry counts modulo 2*DEPTH.
    int m_rcnt  = 0;
    int m_empty = 1;
    int m_uf    = 0;
    int wcnt    = 0;

    function automatic int gray(input int v);
        return (v ^ (v >> 1)) % MOD;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus plus the model update for the coming edge.
    task automatic step(input bit rst, input bit en, input int wc);
        exp_t e;
        int   fire;
        int   level;
        @(negedge clk);
        rst_n   = rst;
        rd_en   = en;
        wq2_ptr = PW'(gray(wc % MOD));
        if (!rst) begin
            m_rcnt  = 0;
            m_empty = 1;
            m_uf    = 0;
            e = '{ptr: 0, addr: 0, empty: 1, ae: 1, level: 0, valid: 0, uf: 0};
        end else begin
            fire    = (en && !m_empty) ? 1 : 0;
            m_uf    = (m_uf != 0 || (en && m_empty != 0)) ? 1 : 0;
            m_rcnt  = (m_rcnt + fire) % MOD;
            level   = ((wc % MOD) - m_rcnt + MOD) % MOD;
            m_empty = (level == 0) ? 1 : 0;
            e.ptr   = gray(m_rcnt);
            e.addr  = m_rcnt % DEPTH;
            e.empty = m_empty;
            e.ae    = (level <= AE) ? 1 : 0;
            e.level = level;
            e.valid = fire;
            e.uf    = m_uf;
        end
        q.push_back(e);
    endtask

    // Monitor: compare every presented output set against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("rd_ptr",          int'(rd_ptr),          e.ptr);
                check("rd_addr",         int'(rd_addr),         e.addr);
                check("rd_empty",        int'(rd_empty),        e.empty);
                check("rd_almost_empty", int'(rd_almost_empty), e.ae);
                check("rd_level",        int'(rd_level),        e.level);
                check("rd_valid",        int'(rd_valid),        e.valid);
                check("rd_underflow",    int'(rd_underflow),    e.uf);
            end
        end
    end

    initial begin
        int lvl;
        int k;
        rst_n   = 1'b0;
        rd_en   = 1'b0;
        wq2_ptr = '0;

        // Reset held two cycles with a read request and a nonzero write pointer.
        step(0, 1, 3);
        step(0, 1, 3);

        // Three entries available, then drain them and try once more.
        step(1, 0, 3);
        for (int i = 0; i < 4; i++) step(1, 1, 3);

        // Full FIFO after reset.
        step(0, 0, 0);
        step(1, 0, 16);
        step(1, 0, 16);

        // Walk the read pointer to 30, then read across the wrap.
        for (int i = 0; i < 16; i++) step(1, 1, 16);
        step(1, 0, 30);
        for (int i = 0; i < 14; i++) step(1, 1, 30);
        step(1, 0, 34);
        for (int i = 0; i < 5; i++) step(1, 1, 34);

        // Write pointer jumps by five entries in one cycle.
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 5);

        // Mid-stream reset, with the sticky underflow set beforehand.
        step(1, 1, 5);
        for (int i = 0; i < 5; i++) step(1, 1, 5);
        step(0, 1, 5);
        step(1, 0, 0);

        // Randomized traffic; the write count never runs more than DEPTH
        // entries ahead of the model's read count.
        wcnt = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                step(0, $urandom_range(0, 1) != 0, wcnt);
                wcnt = 0;
            end else begin
                lvl = (wcnt - m_rcnt + MOD) % MOD;
                k   = $urandom_range(0, 3);
                if (lvl + k > DEPTH) k = DEPTH - lvl;
                wcnt = (wcnt + k) % MOD;
                step(1, $urandom_range(0, 2) != 0, wcnt);
            end
        end

        // Let the monitor drain the scoreboard, with a bounded wait.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
